ss_display_scheduler: RTL and testbench
=======================================

// Module: ss_display_scheduler
// PURPOSE
//  Time-shares the single 4-digit seven-segment display between NREQ game-side clients
//  (e.g. 0 = alert/status, 1 = game timer, 2 = mines remaining).
//  Round-robin with a minimum dwell per client; client 0 preempts.
//  Drives displayed_number into the existing seven-segment display controller.
// PARAMETERS
//  NREQ      3       number of clients (2..8)
//  TICK_DIV  100000  clock_100Mhz cycles per ms_tick (1 ms)
//  DWELL_MS  2000    ms_ticks a granted client keeps the display when others wait
//  BLINK_MS  250     half-period in ms_ticks of alert blink (SS_SCHED_BLINK_EN only)
// PORTS
//  clock_100Mhz      in   1        system clock, 100 MHz
//  reset             in   1        asynchronous, active-high
//  req               in   NREQ     level request per client; bit 0 = urgent client
//  req_num           in   16*NREQ  client i value on [16*i+15:16*i], binary
//  ack               out  NREQ     one-cycle grant pulse to the newly granted client
//  displayed_number  out  16       value to display, clamped 0..9999
//  disp_valid        out  1        1 while a client owns the display
//  active_src        out  3        index of owning client (0 when idle)
//  blank             out  1        1 = downstream should blank all digits
// BEHAVIOUR
//  Reset: async, all outputs 0 except blank=1; state IDLE, rr_ptr=0, dwell=0, tick_cnt=0.
//   Reset asserted mid-dwell aborts immediately; no ack issued on release.
//  Prescaler: tick_cnt 0..TICK_DIV-1 free-running; ms_tick=1 for one cycle at TICK_DIV-1.
//  FSM IDLE -> SWITCH -> SHOW:
//   IDLE: blank=1, disp_valid=0, displayed_number=0. Any req -> SWITCH.
//   SWITCH (1 cycle): grant = req[0] if set, else first set req at/after rr_ptr (wraps
//    NREQ-1 -> 0). ack[grant]=1, active_src=grant, rr_ptr=grant+1 mod NREQ,
//    dwell=DWELL_MS. If req cleared to 0 in this cycle -> IDLE, no ack.
//   SHOW: disp_valid=1, blank=0; displayed_number registers req_num of active_src
//    every cycle (1-cycle latency, live tracking); dwell decrements on ms_tick, saturates at 0.
//  SHOW exits, priority highest first:
//   1. req[active_src]=0 -> SWITCH if any other req set, else IDLE.
//   2. req[0]=1 while active_src!=0 -> SWITCH (preempt, ignores dwell).
//   3. dwell==0 and another client requesting -> SWITCH (round-robin from rr_ptr).
//   4. dwell==0, no other request -> stay, reload dwell=DWELL_MS.
//  Simultaneous events: expiry + req[0] in same cycle -> client 0 granted.
//   Requests rising during SWITCH are seen next SHOW cycle.
//  Arithmetic: req_num > 9999 -> displayed_number=9999 (16-bit unsigned compare).
//   dwell width = clog2(DWELL_MS+1); tick_cnt width = clog2(TICK_DIV).
//  ack: never two bits set; never asserted in IDLE or SHOW.
// CONFIGURATION
//  SS_SCHED_BLINK_EN defined: while SHOW and active_src==0, blank toggles every
//   BLINK_MS ms_ticks, starting at 0 on SWITCH; blink counter reset on every SWITCH.
//  Not defined: blank = (state != SHOW); BLINK_MS unused, no blink counter.
// TESTING (TICK_DIV=4, DWELL_MS=3, NREQ=3)
//  Reset pulse mid-SHOW -> same cycle blank=1, disp_valid=0, displayed_number=0, ack=0.
//  req=3'b010, num1=42 -> one ack=3'b010 in SWITCH; next cycle displayed_number=42,
//   active_src=1; stays on client 1 indefinitely, no further ack.
//  req=3'b110, num1=7, num2=12000 -> alternates 1,2,1,... every 3 ms_ticks (~12 cycles);
//   displayed_number 7 / 9999.
//  Owning client 2, assert req[0] with num0=5 -> SWITCH next cycle, ack=3'b001,
//   displayed_number=5 one cycle later, regardless of dwell.
//  Client 1 drops req while client 2 waits -> SWITCH next cycle, grant 2 without dwell.
//   Last request drops -> IDLE, blank=1.
//  Blink build, BLINK_MS=2, client 0 owns -> blank toggles every 8 cycles; non-blink build
//   -> blank constant 0 in SHOW.

Source files
------------

// File: rtl/ss_display_scheduler.sv
// Round-robin owner arbitration for the shared 4-digit seven-segment display; client 0 preempts.
// Optional alert blink on client 0 is compiled in when SS_SCHED_BLINK_EN is defined.
module ss_display_scheduler #(
    parameter int NREQ     = 3,
    parameter int TICK_DIV = 100000,
    parameter int DWELL_MS = 2000,
    parameter int BLINK_MS = 250
) (
    input  logic                 clock_100Mhz,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_num,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          displayed_number,
    output logic                 disp_valid,
    output logic [2:0]           active_src,
    output logic                 blank
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DWELL_MS + 1);

    if (NREQ < 2 || NREQ > 8 || BLINK_MS < 1) begin : g_param_err
        $error("ss_display_scheduler: NREQ must be 2..8 and BLINK_MS >= 1");
    end

    typedef enum logic [1:0] {IDLE, SWITCH, SHOW} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q;
    logic            ms_tick;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [2:0]      src_q, src_d;
    logic [15:0]     num_q, num_d;

    logic [15:0]     num_arr [8];
    logic [7:0]      req8;
    logic [NREQ-1:0] req_rot;
    logic [3:0]      rot_sum;
    logic [2:0]      grant;
    logic            others_req;

    // Unused slots read as 0 so a 3-bit index never leaves the array.
    for (genvar i = 0; i < 8; i++) begin : g_num
        if (i < NREQ) begin : g_used
            assign num_arr[i] = req_num[16*i +: 16];
        end else begin : g_unused
            assign num_arr[i] = 16'd0;
        end
    end

    function automatic logic [15:0] clamp(input logic [15:0] v);
        return (v > 16'd9999) ? 16'd9999 : v;
    endfunction

    assign req8       = 8'(req);
    assign req_rot    = NREQ'({req, req} >> rr_ptr_q);
    assign others_req = |(req8 & ~(8'd1 << src_q));
    assign ms_tick    = (tick_q == TW'(TICK_DIV - 1));

    always_comb begin
        rot_sum = 4'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) rot_sum = {1'b0, rr_ptr_q} + 4'(i);
        end
        if (rot_sum >= 4'(NREQ)) rot_sum = rot_sum - 4'(NREQ);
        grant = req[0] ? 3'd0 : rot_sum[2:0];
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        num_d    = num_q;
        ack      = '0;
        unique case (state_q)
            IDLE: begin
                src_d = 3'd0;
                num_d = 16'd0;
                if (|req) state_d = SWITCH;
            end
            SWITCH: begin
                if (|req) begin
                    ack      = NREQ'(1) << grant;
                    src_d    = grant;
                    rr_ptr_d = (grant == 3'(NREQ - 1)) ? 3'd0 : grant + 3'd1;
                    dwell_d  = DW'(DWELL_MS);
                    num_d    = clamp(num_arr[grant]);
                    state_d  = SHOW;
                end else begin
                    src_d   = 3'd0;
                    num_d   = 16'd0;
                    state_d = IDLE;
                end
            end
            SHOW: begin
                num_d = clamp(num_arr[src_q]);
                if (ms_tick && dwell_q != '0) dwell_d = dwell_q - DW'(1);
                if (!req8[src_q]) begin
                    if (|req) begin
                        state_d = SWITCH;
                    end else begin
                        state_d = IDLE;
                        src_d   = 3'd0;
                        num_d   = 16'd0;
                    end
                end else if (req[0] && src_q != 3'd0) begin
                    state_d = SWITCH;
                end else if (dwell_q == '0) begin
                    if (others_req) state_d = SWITCH;
                    else            dwell_d = DW'(DWELL_MS);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            dwell_q  <= '0;
            rr_ptr_q <= 3'd0;
            src_q    <= 3'd0;
            num_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            tick_q   <= ms_tick ? '0 : tick_q + TW'(1);
            dwell_q  <= dwell_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            num_q    <= num_d;
        end
    end

    assign displayed_number = num_q;
    assign active_src       = src_q;
    assign disp_valid       = (state_q == SHOW);

`ifdef SS_SCHED_BLINK_EN
    localparam int BW = $clog2(BLINK_MS + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    // Phase restarts on every grant so an alert always opens with digits lit.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_q == SWITCH) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (state_q == SHOW && ms_tick) begin
            if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blank = (state_q != SHOW) || (src_q == 3'd0 && blink_q);
`else
    assign blank = (state_q != SHOW);
`endif

endmodule

// File: tb/tb_ss_display_scheduler.sv
// Directed bench for ss_display_scheduler with TICK_DIV=4, DWELL_MS=3, NREQ=3, BLINK_MS=2.
module tb_ss_display_scheduler;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] n0, n1, n2;
    logic [2:0]  ack;
    logic [15:0] displayed_number;
    logic        disp_valid;
    logic [2:0]  active_src;
    logic        blank;

    int total = 0;
    int bad   = 0;

    ss_display_scheduler #(
        .NREQ(3), .TICK_DIV(4), .DWELL_MS(3), .BLINK_MS(2)
    ) dut (
        .clock_100Mhz    (clk),
        .reset           (reset),
        .req             (req),
        .req_num         ({n2, n1, n0}),
        .ack             (ack),
        .displayed_number(displayed_number),
        .disp_valid      (disp_valid),
        .active_src      (active_src),
        .blank           (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [15:0] n0, n1, n2;
        int          wait_c;
        logic [15:0] e_disp;
        logic [2:0]  e_src;
        logic        e_valid;
        logic        e_blank;
    } vec_t;

    vec_t vecs [10];

    int ack_cnt, alt_err, disp_err, len_err, ack_err, switches, seg_len;
    int valid_err, blank_hi, toggles, run_len, run_err;
    logic [2:0] last_ack, prev_owner, exp_owner;
    logic in_seg, prev_blank;

    initial begin
        vecs[0] = '{3'b010, 16'd0, 16'd42,    16'd0,     3, 16'd42,   3'd1, 1'b1, 1'b0};
        vecs[1] = '{3'b010, 16'd0, 16'd4321,  16'd0,     1, 16'd4321, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{3'b010, 16'd0, 16'd9999,  16'd0,     1, 16'd9999, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{3'b010, 16'd0, 16'd10000, 16'd0,     1, 16'd9999, 3'd1, 1'b1, 1'b0};
        vecs[4] = '{3'b100, 16'd0, 16'd0,     16'd65535, 3, 16'd9999, 3'd2, 1'b1, 1'b0};
        vecs[5] = '{3'b100, 16'd0, 16'd0,     16'd0,     1, 16'd0,    3'd2, 1'b1, 1'b0};
        vecs[6] = '{3'b001, 16'd5, 16'd0,     16'd0,     3, 16'd5,    3'd0, 1'b1, 1'b0};
        vecs[7] = '{3'b000, 16'd0, 16'd0,     16'd0,     1, 16'd0,    3'd0, 1'b0, 1'b1};
        vecs[8] = '{3'b100, 16'd0, 16'd0,     16'd1,     3, 16'd1,    3'd2, 1'b1, 1'b0};
        vecs[9] = '{3'b000, 16'd0, 16'd0,     16'd0,     1, 16'd0,    3'd0, 1'b0, 1'b1};

        reset = 1'b1; req = 3'b000; n0 = 16'd0; n1 = 16'd0; n2 = 16'd0;
        cycles(2);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_valid", 32'(disp_valid), 32'd0);
        check("rst_disp",  32'(displayed_number), 32'd0);
        check("rst_src",   32'(active_src), 32'd0);
        check("rst_ack",   32'(ack), 32'd0);
        reset = 1'b0;
        cycles(1);

        // rr_ptr starts at 0: first grant of {2,1} goes to 1; dropping 1 hands over to 2 at once.
        req = 3'b110; n1 = 16'd11; n2 = 16'd22;
        cycles(1);
        check("d_sw_ack", 32'(ack), 32'b010);
        cycles(1);
        check("d_src1", 32'(active_src), 32'd1);
        check("d_disp1", 32'(displayed_number), 32'd11);
        req = 3'b100;
        cycles(1);
        check("d_drop_ack", 32'(ack), 32'b100);
        check("d_drop_valid", 32'(disp_valid), 32'd0);
        cycles(1);
        check("d_src2", 32'(active_src), 32'd2);
        req = 3'b000;
        cycles(1);
        check("d_idle_blank", 32'(blank), 32'd1);
        check("d_idle_valid", 32'(disp_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req; n0 = vecs[i].n0; n1 = vecs[i].n1; n2 = vecs[i].n2;
            cycles(vecs[i].wait_c);
            check($sformatf("vec%0d_disp", i),  32'(displayed_number), 32'(vecs[i].e_disp));
            check($sformatf("vec%0d_src", i),   32'(active_src),       32'(vecs[i].e_src));
            check($sformatf("vec%0d_valid", i), 32'(disp_valid),       32'(vecs[i].e_valid));
            check($sformatf("vec%0d_blank", i), 32'(blank),            32'(vecs[i].e_blank));
        end

        // A lone requester gets exactly one ack and keeps the display.
        req = 3'b010; n1 = 16'd42; ack_cnt = 0; last_ack = 3'b000;
        for (int i = 0; i < 30; i++) begin
            cycles(1);
            if (ack != 3'b000) begin
                ack_cnt++;
                last_ack = ack;
            end
        end
        check("lone_ack_cnt", 32'(ack_cnt), 32'd1);
        check("lone_ack_val", 32'(last_ack), 32'b010);
        check("lone_src", 32'(active_src), 32'd1);
        check("lone_disp", 32'(displayed_number), 32'd42);

        // Client 0 preempts client 2 straight after its grant, dwell still full.
        req = 3'b100; n2 = 16'd77;
        cycles(2);
        check("pre_src2", 32'(active_src), 32'd2);
        req = 3'b101; n0 = 16'd5;
        cycles(1);
        check("pre_ack", 32'(ack), 32'b001);
        cycles(1);
        check("pre_disp", 32'(displayed_number), 32'd5);
        check("pre_src0", 32'(active_src), 32'd0);

        // Clients 1 and 2 share: 10..13 SHOW cycles each (3 ms_ticks of 4 cycles + phase).
        req = 3'b110; n0 = 16'd0; n1 = 16'd7; n2 = 16'd12000;
        cycles(2);
        alt_err = 0; disp_err = 0; len_err = 0; ack_err = 0; switches = 0; seg_len = 0;
        in_seg = 1'b0; prev_owner = 3'd2;
        for (int i = 0; i < 90; i++) begin
            if (disp_valid) begin
                if (!in_seg) begin
                    in_seg = 1'b1;
                    seg_len = 0;
                    exp_owner = (prev_owner == 3'd1) ? 3'd2 : 3'd1;
                    if (active_src != exp_owner) alt_err++;
                    prev_owner = active_src;
                end
                seg_len++;
                if (displayed_number != ((active_src == 3'd1) ? 16'd7 : 16'd9999)) disp_err++;
            end else begin
                if (in_seg) begin
                    if (seg_len < 10 || seg_len > 13) len_err++;
                    switches++;
                    in_seg = 1'b0;
                end
                if (ack != ((prev_owner == 3'd1) ? 3'b100 : 3'b010)) ack_err++;
            end
            cycles(1);
        end
        check("alt_owner_errs", 32'(alt_err), 32'd0);
        check("alt_disp_errs", 32'(disp_err), 32'd0);
        check("alt_len_errs", 32'(len_err), 32'd0);
        check("alt_ack_errs", 32'(ack_err), 32'd0);
        check("alt_switches_ge5", 32'(switches >= 5), 32'd1);

        // Client 0 alone: blank is steady 0, or toggles every 8 cycles in the blink build.
        req = 3'b001; n0 = 16'd3;
        cycles(3);
        valid_err = 0; blank_hi = 0; toggles = 0; run_len = 0; run_err = 0;
        prev_blank = blank;
        for (int i = 0; i < 48; i++) begin
            if (!disp_valid || active_src != 3'd0) valid_err++;
            if (blank) blank_hi++;
            run_len++;
            if (blank != prev_blank) begin
                if (toggles > 0 && run_len != 9) run_err++;
                toggles++;
                run_len = 1;
            end
            prev_blank = blank;
            cycles(1);
        end
        check("blink_owner_errs", 32'(valid_err), 32'd0);
`ifdef SS_SCHED_BLINK_EN
        check("blink_run_errs", 32'(run_err), 32'd0);
        check("blink_toggles_ge4", 32'(toggles >= 4), 32'd1);
`else
        check("steady_blank_hi", 32'(blank_hi), 32'd0);
`endif

        // Reset in mid-SHOW clears outputs immediately; release does not ack by itself.
        reset = 1'b1;
        #1;
        check("mid_rst_blank", 32'(blank), 32'd1);
        check("mid_rst_valid", 32'(disp_valid), 32'd0);
        check("mid_rst_disp", 32'(displayed_number), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        cycles(2);
        reset = 1'b0;
        #1;
        check("rel_ack", 32'(ack), 32'd0);
        check("rel_valid", 32'(disp_valid), 32'd0);
        req = 3'b000;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
